// File: rtl/conv2d_stream.sv
// conv2d_stream: NUM_F parallel 3x3 convolutions over a raster pixel stream using two line
// buffers and a 3x3 window, with optional zero padding, saturation and ReLU.
module conv2d_stream #(
    parameter int IMG_W      = 30,
    parameter int IMG_H      = 30,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_F      = 8,
    parameter int FRAC       = 8,
    parameter int PAD        = 1,
    parameter int RELU       = 1,
    localparam int WA        = $clog2(NUM_F*10)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DATA_WIDTH-1:0]         in_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [NUM_F*DATA_WIDTH-1:0]   out_data_o,
    output logic                          out_last_o,
    input  logic                          w_we_i,
    input  logic [WA-1:0]                 w_addr_i,
    input  logic [DATA_WIDTH-1:0]         w_data_i
);
    localparam int AW = 2*DATA_WIDTH+4;
    localparam int NW = NUM_F*10;
    localparam int CW = $clog2(IMG_W+2);
    localparam int RW = $clog2(IMG_H+2);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2;
    localparam logic [CW-1:0] C_W = CW'(IMG_W), C_LAST = CW'(IMG_W-1), C_END = CW'(IMG_W-1+PAD), C_EMIT = CW'(2-PAD);
    localparam logic [RW-1:0] R_H = RW'(IMG_H), R_LAST = RW'(IMG_H-1), R_END = RW'(IMG_H-1+PAD), R_EMIT = RW'(2-PAD);
    localparam logic [RW-1:0] R_ONE = RW'(1), R_TWO = RW'(2);
    localparam logic signed [AW-1:0] MAXV = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    logic [1:0] state_q, state_d;
    logic [RW-1:0] r_q;
    logic [CW-1:0] c_q;
    logic gen_q, v1_q, last1_q, out_valid_q, out_last_q, done_q;
    logic [NUM_F*DATA_WIDTH-1:0] out_data_q, res_c;
    logic signed [DATA_WIDTH-1:0] win_q [9];
    logic signed [DATA_WIDTH-1:0] w_q [NW];
    logic [DATA_WIDTH-1:0] lb0_q [IMG_W];
    logic [DATA_WIDTH-1:0] lb1_q [IMG_W];
    logic signed [DATA_WIDTH-1:0] col_c [3];
    logic stall, real_col, real_pos, in_hs, step, at_end, emit;

    // The stream walks an (IMG_H+PAD) x (IMG_W+PAD) grid; the extra column/row are zero-filled
    // steps without input that let the window centre reach the right and bottom edges.
    assign stall      = out_valid_q && !out_ready_i;
    assign real_col   = c_q < C_W;
    assign real_pos   = real_col && r_q < R_H;
    assign in_ready_o = state_q == S_RUN && !stall && real_pos;
    assign in_hs      = in_valid_i && in_ready_o;
    assign step       = in_hs || (gen_q && !stall && !real_pos);
    assign at_end     = r_q == R_END && c_q == C_END;
    assign emit       = r_q >= R_EMIT && c_q >= C_EMIT;
    assign col_c[0]   = real_col && r_q >= R_TWO ? lb1_q[c_q] : '0;
    assign col_c[1]   = real_col && r_q >= R_ONE ? lb0_q[c_q] : '0;
    assign col_c[2]   = real_pos ? in_data_i : '0;

    assign state_d = (state_q == S_IDLE && start_i) ? S_RUN :
                     (in_hs && r_q == R_LAST && c_q == C_LAST) ? S_FLUSH :
                     (state_q == S_FLUSH && out_valid_q && out_ready_i && out_last_q) ? S_IDLE : state_q;

    assign busy_o      = state_q != S_IDLE;
    assign done_o      = done_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_data_o  = out_data_q;

    for (genvar f = 0; f < NUM_F; f++) begin : g_f
        logic signed [AW-1:0] acc_c, sh_c;
        logic [DATA_WIDTH-1:0] sat_c;
        always_comb begin
            acc_c = AW'(w_q[f*10+9]) <<< FRAC;
            for (int k = 0; k < 9; k++) acc_c = acc_c + AW'(win_q[k]) * AW'(w_q[f*10+k]);
        end
        assign sh_c  = acc_c >>> FRAC;
        assign sat_c = sh_c > MAXV ? MAXV[DATA_WIDTH-1:0] : sh_c < MINV ? MINV[DATA_WIDTH-1:0] : sh_c[DATA_WIDTH-1:0];
        assign res_c[f*DATA_WIDTH +: DATA_WIDTH] = (RELU != 0 && sat_c[DATA_WIDTH-1]) ? '0 : sat_c;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            c_q         <= '0;
            gen_q       <= 1'b0;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= state_q == S_FLUSH && state_d == S_IDLE;
            if (state_q == S_IDLE && start_i) gen_q <= 1'b1;
            if (step) begin
                gen_q <= !at_end;
                c_q   <= (at_end || c_q == C_END) ? '0 : c_q + CW'(1);
                r_q   <= at_end ? '0 : r_q + RW'(c_q == C_END);
                // A new row starts with the two older window columns cleared so taps never wrap.
                for (int i = 0; i < 3; i++) begin
                    win_q[i*3]   <= c_q == '0 ? '0 : win_q[i*3+1];
                    win_q[i*3+1] <= c_q == '0 ? '0 : win_q[i*3+2];
                    win_q[i*3+2] <= col_c[i];
                end
                if (real_pos) begin
                    lb1_q[c_q] <= lb0_q[c_q];
                    lb0_q[c_q] <= in_data_i;
                end
            end
            if (!stall) begin
                v1_q        <= step && emit;
                last1_q     <= at_end;
                out_valid_q <= v1_q;
                out_last_q  <= v1_q && last1_q;
                if (v1_q) out_data_q <= res_c;
            end
        end
    end

    always_ff @(posedge clk_i)
        if (w_we_i && state_q == S_IDLE && 32'(w_addr_i) < NW) w_q[w_addr_i] <= w_data_i;
endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: randomized frames on a padded/ReLU instance and a valid/no-ReLU instance,
// compared against a direct convolution model.
module tb_conv2d_stream;
    localparam int W = 6, H = 5, NF = 2, DW = 16, FR = 8, WA = $clog2(NF*10);

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0, w_data = '0;
    logic [WA-1:0] w_addr = '0;
    logic [1:0] w_en = '0;
    int sel = 0;
    logic [1:0] busy, done, in_ready, out_valid, out_last;
    logic [NF*DW-1:0] out_data [2];
    logic [NF*DW-1:0] got [W*H];
    int wt [NF*10];
    int img [W*H];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    conv2d_stream #(.IMG_W(W), .IMG_H(H), .DATA_WIDTH(DW), .NUM_F(NF), .FRAC(FR), .PAD(1), .RELU(1)) u_pad (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start && sel == 0), .busy_o(busy[0]), .done_o(done[0]),
        .in_valid_i(in_valid && sel == 0), .in_ready_o(in_ready[0]), .in_data_i(in_data),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .out_data_o(out_data[0]), .out_last_o(out_last[0]),
        .w_we_i(w_en[0]), .w_addr_i(w_addr), .w_data_i(w_data));

    conv2d_stream #(.IMG_W(W), .IMG_H(H), .DATA_WIDTH(DW), .NUM_F(NF), .FRAC(FR), .PAD(0), .RELU(0)) u_val (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start && sel == 1), .busy_o(busy[1]), .done_o(done[1]),
        .in_valid_i(in_valid && sel == 1), .in_ready_o(in_ready[1]), .in_data_i(in_data),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .out_data_o(out_data[1]), .out_last_o(out_last[1]),
        .w_we_i(w_en[1]), .w_addr_i(w_addr), .w_data_i(w_data));

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [NF*DW-1:0] exp_word(input int pad, input int relu, input int oc);
        int ow = pad != 0 ? W : W-2;
        int y = oc / ow;
        int x = oc % ow;
        logic [NF*DW-1:0] r = '0;
        for (int f = 0; f < NF; f++) begin
            longint acc = longint'(wt[f*10+9]) <<< FR;
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++) begin
                    int iy = y + ky - pad;
                    int ix = x + kx - pad;
                    if (iy >= 0 && iy < H && ix >= 0 && ix < W)
                        acc += longint'(img[iy*W+ix]) * longint'(wt[f*10+ky*3+kx]);
                end
            acc = acc >>> FR;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            if (relu != 0 && acc < 0) acc = 0;
            r[f*DW +: DW] = DW'(acc);
        end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_busy", busy[s], 0);
            check("rst_done", done[s], 0);
            check("rst_in_ready", in_ready[s], 0);
            check("rst_out_valid", out_valid[s], 0);
            check("rst_out_last", out_last[s], 0);
            check("rst_out_data", out_data[s], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_w();
        for (int a = 0; a < NF*10; a++) begin
            @(negedge clk);
            w_en = 2'b11;
            w_addr = WA'(a);
            w_data = DW'(wt[a]);
        end
        @(negedge clk);
        w_en = 2'b00;
    endtask

    task automatic run_frame(input int s, input int pin, input int pout, input bit lat, input bit garb, input int rst_at);
        int pad = s == 0 ? 1 : 0;
        int n_out = pad != 0 ? W*H : (W-2)*(H-2);
        int en_px = pad != 0 ? W+1 : 2*W+2;
        int px = 0, oc = 0, cyc = 0, last_cyc = -10, hs_cyc = -100, ov_cyc = -1, dn = 0;
        bit hold = 1'b0;
        logic [NF*DW+1:0] held = '0;
        sel = s;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (dn == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (px == rst_at) break;
            start = busy[s] && cyc == 7;
            w_en = (garb && busy[s]) ? 2'(1 << s) : 2'b00;
            w_addr = WA'($urandom);
            w_data = DW'($urandom);
            in_valid = px < W*H && $urandom_range(99) < pin;
            in_data = DW'(img[px < W*H ? px : 0]);
            out_ready = $urandom_range(99) < pout;
            #1;
            if (hold) check("hold", {out_valid[s], out_last[s], out_data[s]}, held);
            hold = 1'b0;
            if (done[s]) begin
                dn++;
                check("done_cyc", cyc, last_cyc + 1);
            end
            if (in_valid && in_ready[s]) begin
                if (px == en_px) hs_cyc = cyc;
                px++;
            end
            if (out_valid[s] && ov_cyc < 0) ov_cyc = cyc;
            if (out_valid[s] && out_ready) begin
                check("no_extra", oc < n_out, 1);
                if (oc < n_out) begin
                    check("data", out_data[s], exp_word(pad, pad, oc));
                    check("last", out_last[s], oc == n_out - 1);
                    got[oc] = out_data[s];
                end
                if (oc == n_out - 1) last_cyc = cyc;
                oc++;
            end else if (out_valid[s]) begin
                hold = 1'b1;
                held = {1'b1, out_last[s], out_data[s]};
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        w_en = 2'b00;
        out_ready = 1'b1;
        if (rst_at < 0) begin
            check("done_seen", dn, 1);
            check("count", oc, n_out);
            if (lat) check("latency", ov_cyc - hs_cyc, 2);
            @(negedge clk);
            #1;
            check("done_pulse", done[s], 0);
            check("idle", busy[s], 0);
        end
    endtask

    initial begin
        do_reset();
        foreach (wt[i]) wt[i] = (i % 10 == 4) ? 256 : 0;
        foreach (img[i]) img[i] = i + 1;
        load_w();
        run_frame(0, 100, 100, 1, 0, -1);
        check("ident_first", got[0][DW-1:0], 1);
        check("ident_lastpx", got[W*H-1][DW-1:0], W*H);
        run_frame(1, 100, 100, 1, 0, -1);
        check("ident_valid", got[0][DW-1:0], W+2);

        foreach (wt[i]) wt[i] = (i % 10 == 9) ? 0 : 256;
        foreach (img[i]) img[i] = 256;
        load_w();
        run_frame(0, 100, 100, 0, 0, -1);
        check("ones_corner", got[0][DW-1:0], 1024);
        check("ones_edge", got[1][DW-1:0], 1536);
        check("ones_inner", got[W+1][DW-1:0], 2304);
        run_frame(1, 100, 100, 0, 0, -1);
        check("ones_valid", got[0][DW-1:0], 2304);

        foreach (wt[i]) wt[i] = (i % 10 == 9) ? 0 : (i < 10 ? 32767 : -32767);
        foreach (img[i]) img[i] = 32767;
        load_w();
        run_frame(0, 100, 100, 0, 0, -1);
        check("sat_relu", got[W+1], 32'h0000_7fff);
        run_frame(1, 100, 100, 0, 0, -1);
        check("sat_norelu", got[0], 32'h8000_7fff);

        for (int it = 0; it < 4; it++) begin
            foreach (wt[i]) wt[i] = (i % 10 == 9) ? int'($urandom_range(4000)) - 2000 : int'($urandom_range(600)) - 300;
            foreach (img[i]) img[i] = int'($urandom_range(6000)) - 3000;
            load_w();
            run_frame(it % 2, 60, 50, 0, it == 2, -1);
        end
        foreach (wt[i]) wt[i] = int'($signed(16'($urandom)));
        foreach (img[i]) img[i] = int'($signed(16'($urandom)));
        load_w();
        run_frame(0, 70, 50, 0, 0, -1);
        run_frame(1, 70, 50, 0, 0, -1);

        run_frame(0, 100, 100, 0, 0, 10);
        do_reset();
        run_frame(0, 80, 60, 0, 1, -1);
        run_frame(1, 80, 60, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 Parameter IMG_W, default 30, input frame width in pixels (>=3).
REQ-002 Parameter IMG_H, default 30, input frame height in pixels (>=3).
REQ-003 Parameter DATA_WIDTH, default 16, signed fixed-point pixel/weight/output width.
REQ-004 Parameter NUM_F, default 8, number of 3x3 filters computed in parallel.
REQ-005 Parameter FRAC, default 8, fractional bits of all operands.
REQ-006 Parameter PAD, default 1; 1 = zero-padded "same" output (IMG_W x IMG_H), 0 = "valid" output ((IMG_W-2) x (IMG_H-2)).
REQ-007 Parameter RELU, default 1; 1 = clamp negative results to 0.
REQ-008 Block SHALL use one clock; reset is synchronous and active-low.
REQ-009 clk  in  1  rising-edge clock.
REQ-010 reset_n  in  1  synchronous active-low reset.
REQ-011 start  in  1  one-cycle pulse, begins a frame when in IDLE.
REQ-012 busy  out  1  high in RUN and FLUSH.
REQ-013 done  out  1  one-cycle pulse after the last output is accepted.
REQ-014 in_valid / in_ready  in / out  1 / 1  raster-order pixel handshake.
REQ-015 in_data  in  DATA_WIDTH  input pixel.
REQ-016 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-017 out_data  out  NUM_F*DATA_WIDTH  filter f result in bits [f*DATA_WIDTH +: DATA_WIDTH].
REQ-018 out_last  out  1  high with the final output pixel of the frame.
REQ-019 w_we, w_addr, w_data  in  1, clog2(NUM_F*10), DATA_WIDTH  weight write port; addr = f*10+k, k 0..8 kernel row-major, k=9 bias.

Function
REQ-020 FSM states IDLE, RUN, FLUSH; IDLE->RUN on start; RUN->FLUSH once pixel IMG_W*IMG_H-1 is accepted; FLUSH->IDLE once the out_last output is accepted, with done pulsed in that same transition cycle.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 w_we SHALL write only in IDLE; writes in RUN/FLUSH are dropped; addresses >= NUM_F*10 are ignored.
REQ-023 Two line buffers of IMG_W entries plus a 3x3 window register SHALL hold the neighbourhood; no full-frame storage.
REQ-024 in_ready SHALL be high only in RUN and only when the output stage is not stalled (out_valid && !out_ready).
REQ-025 PAD=1: output (y,x) is produced after input (min(y+1,IMG_H-1), min(x+1,IMG_W-1)) is accepted; out-of-frame taps read as 0; outputs still owed after the final input are produced in FLUSH without input.
REQ-026 PAD=0: output (y,x), 0<=y<IMG_H-2, 0<=x<IMG_W-2, is produced when input (y+2,x+2) is accepted; FLUSH produces no extra pixels.
REQ-027 Window SHALL not wrap across row boundaries: column taps beyond the row edge are 0 (PAD=1) or not emitted (PAD=0).
REQ-028 Per filter: acc = (bias <<< FRAC) + sum of 9 signed pixel*weight products, width 2*DATA_WIDTH+4, no internal overflow.
REQ-029 Result = acc >>> FRAC (arithmetic, truncating), saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then ReLU if RELU=1.
REQ-030 Latency: out_valid SHALL assert exactly 2 cycles after the enabling input handshake when out_ready is held high; throughput 1 pixel/cycle.
REQ-031 out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-032 Outputs SHALL be emitted in raster order, exactly IMG_W*IMG_H (PAD=1) or (IMG_W-2)*(IMG_H-2) (PAD=0) per frame.

Reset
REQ-033 reset_n low at a clock edge SHALL force IDLE, busy=0, done=0, in_ready=0, out_valid=0, out_last=0, out_data=0, clear line buffers and position counters, in any state including mid-frame.
REQ-034 Weights and biases SHALL retain contents through reset (retain-last-written; not reset).

Verification
REQ-035 Identity kernel (centre=256, others 0, bias 0), PAD=1, 4x4 ramp 1..16 (Q8.8 raw) -> output equals input, 16 outputs, out_last on 16th, done next accept cycle.
REQ-036 All-ones kernel (w=256), bias 0, PAD=1, 4x4 frame of 256 -> corners 1024, edges 1536, interior 2304.
REQ-037 Same stimulus, PAD=0 -> 4 outputs, all 2304; no FLUSH outputs.
REQ-038 Weights 0x7FFF all taps, pixels 0x7FFF -> 0x7FFF (saturated); negate weights with RELU=1 -> 0; RELU=0 -> 0x8000.
REQ-039 Random out_ready deassertion (50%) over 30x30 frame -> output sequence identical to stall-free run, no drop/duplicate.
REQ-040 reset_n low at pixel 100 then new start -> clean frame, outputs match golden; w_we during RUN leaves weights unchanged.
